keccak_arbiter: RTL
===================

# keccak_arbiter

Shares the single Keccak_Dilithium hash core between `N_REQ` requesters, e.g. the ExpandA XOF sampler, the rejection sampler and the H/CRH hash path. It grants the core for a whole message, from first absorbed word to final squeezed block, and picks winners round-robin. On release it applies a core reset flush, so the next owner starts from a clean padder and permutation state. It sits between the requester FSMs and the core, and is the only driver of the core's input pins.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..4.
- `FLUSH_CYC`, default 2: cycles of core reset driven after each release, at least 1.
- `OUT_W`, default 1344: width of the core output block.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: requester wants the core. Held until `gnt`.
- `rel` in N_REQ: one-cycle release pulse from the owner.
- `gnt` out N_REQ: one-hot ownership, registered.
- `r_in` in 64·N_REQ: message words, requester i at [64i+63:64i].
- `r_in_ready`, `r_is_last`, `r_squeeze`, `r_hold` in N_REQ each: per-requester core controls.
- `r_byte_num` in 3·N_REQ: per-requester byte count.
- `r_mode` in 2·N_REQ: per-requester mode.
- `r_buffer_full` out N_REQ: the core's buffer_full for the owner; 1 for every other requester.
- `r_buffer_last` out N_REQ: the core's buffer_last for the owner; 0 otherwise.
- `r_out_ready` out N_REQ: the core's out_ready for the owner; 0 otherwise.
- `r_out` out OUT_W: core output, broadcast to all requesters. Valid only where `r_out_ready` is set.
- `k_reset` out 1: core reset, equal to `reset | flushing`.
- `k_in` out 64, `k_in_ready` out 1, `k_is_last` out 1, `k_squeeze` out 1, `k_hold` out 1, `k_byte_num` out 3, `k_mode` out 2: core inputs.
- `k_buffer_full`, `k_buffer_last`, `k_out_ready` in 1 each; `k_out` in OUT_W: core outputs.

## Operation
States:
- IDLE: all `k_*` data and control outputs are 0. When any `req` bit is set, choose the first set bit at or after `(last+1) mod N_REQ`. Set `gnt` to that one-hot value, latch `last`, and go to BUSY on the next edge.
- BUSY: route the owner's `r_*` signals to `k_*` combinationally, and route `k_*` back to the owner only.
  - Owner's `rel` → clear `gnt`, load the flush counter with `FLUSH_CYC`, go to FLUSH.
  - `rel` from a non-owner is ignored.
  - `req` from other requesters is ignored until IDLE.
- FLUSH: hold `k_reset` at 1 and all `k_*` controls at 0. Decrement the counter each cycle. Go to IDLE in the cycle it reaches 0, so `k_reset` is high for exactly `FLUSH_CYC` cycles.
- Outside BUSY every requester sees `buffer_full=1`, `buffer_last=0`, `out_ready=0`. This prevents words being pushed to a core the requester does not own.
- Rotation pointer `last` resets to `N_REQ-1`, so requester 0 wins first.
- The owner must deassert `req` by the cycle of `rel`. A `req` still high when IDLE is re-entered is treated as a new request; round-robin then favours the others.
- `reset` mid-message: state goes to IDLE, `gnt` to 0, `last` to `N_REQ-1`. No flush is needed because `k_reset=reset`.

## Timing
- Reset values: `gnt=0`, all `r_buffer_full=1`, all `r_buffer_last=0`, all `r_out_ready=0`, `k_reset=1` during reset, all `k_*` controls 0.
- Latency from `req` to `gnt` is 1 cycle from IDLE. The first word can be presented in the same cycle `gnt` rises.
- Forward paths `r_*`→`k_*` and return paths `k_*`→`r_*` are combinational: zero added latency on the core handshake.
- Release to next grant takes `FLUSH_CYC+2` cycles: BUSY→FLUSH, `FLUSH_CYC` cycles of flush, then the IDLE arbitration cycle.
- `rel` in the same cycle as the owner's `r_in_ready`: the word is forwarded this cycle, and the flush discards it.

## Structure
- Shared package holds the core mode constants (XOF=00, KDF/PRF=01, H=10, G=11) and `KECCAK_OUT_W=1344`.
- One natural sub-module, `rr_pick`: a combinational round-robin one-hot picker taking `req` and `last` and returning the winner.
- The FSM, flush counter and mux/demux live in the top level.

## Test plan
- Single requester: req0=1 → gnt=01 after 1 cycle. A 34-byte H-mode message (`r_mode[1:0]=10`) produces `r_out_ready[0]=1` with the correct SHA3-256 digest, and `r_out_ready[1]` stays 0.
- Contention: req=11 from reset → gnt=01. Then rel0 → `k_reset` high for 2 cycles → gnt=10 on cycle 4 after rel.
- Fairness: req=11 held continuously → grants alternate 01,10,01,10 over 4 messages.
- Isolation: while gnt=01, requester 1 drives `in_ready=1` and `rel=1` → `k_in` unchanged, `r_buffer_full[1]=1`, no state change.
- Back-to-back reuse: XOF squeeze of 3 blocks by requester 0, release, then G-mode hash by requester 1 → digest matches the golden model, with no residue from the prior state.
- Reset mid-absorb: assert `reset` one cycle while gnt=10 → gnt=0, `last=N_REQ-1`; next req=11 grants 01.

Source files
------------

// File: rtl/keccak_arbiter_pkg.sv
// Shared definitions for the Keccak core arbiter: core mode encodings,
// output block width and the arbiter FSM state type.
package keccak_arbiter_pkg;

  localparam int unsigned KECCAK_OUT_W = 1344;

  typedef enum logic [1:0] {
    ModeXof = 2'b00,
    ModeKdf = 2'b01,
    ModeH   = 2'b10,
    ModeG   = 2'b11
  } keccak_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusy  = 2'b01,
    StFlush = 2'b10
  } arb_state_e;

endpackage

// File: rtl/keccak_arbiter_if.sv
// Pin bundle between the arbiter (master) and the shared Keccak core (slave).
interface keccak_arbiter_if #(
  parameter int unsigned OUT_W = keccak_arbiter_pkg::KECCAK_OUT_W
) ();

  logic             core_reset;
  logic [63:0]      in_data;
  logic             in_ready;
  logic             is_last;
  logic             squeeze;
  logic             hold;
  logic [2:0]       byte_num;
  logic [1:0]       mode;
  logic             buffer_full;
  logic             buffer_last;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output core_reset, in_data, in_ready, is_last, squeeze, hold, byte_num, mode,
    input  buffer_full, buffer_last, out_ready, out_data
  );

  modport slave (
    input  core_reset, in_data, in_ready, is_last, squeeze, hold, byte_num, mode,
    output buffer_full, buffer_last, out_ready, out_data
  );

endinterface

// File: rtl/keccak_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module keccak_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IdxW  = (N_REQ > 2) ? 2 : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(last_i) + k) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o      = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Grants the shared Keccak core to one requester per message, round-robin, and
// holds the core in reset for FLUSH_CYC cycles after every release.
module keccak_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned OUT_W     = keccak_arbiter_pkg::KECCAK_OUT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ-1:0]     rel_i,
  output logic [N_REQ-1:0]     gnt_o,
  input  logic [64*N_REQ-1:0]  r_in_i,
  input  logic [N_REQ-1:0]     r_in_ready_i,
  input  logic [N_REQ-1:0]     r_is_last_i,
  input  logic [N_REQ-1:0]     r_squeeze_i,
  input  logic [N_REQ-1:0]     r_hold_i,
  input  logic [3*N_REQ-1:0]   r_byte_num_i,
  input  logic [2*N_REQ-1:0]   r_mode_i,
  output logic [N_REQ-1:0]     r_buffer_full_o,
  output logic [N_REQ-1:0]     r_buffer_last_o,
  output logic [N_REQ-1:0]     r_out_ready_o,
  output logic [OUT_W-1:0]     r_out_o,
  keccak_arbiter_if.master     k
);

  import keccak_arbiter_pkg::*;

  localparam int unsigned IdxW = (N_REQ > 2) ? 2 : 1;
  localparam int unsigned CntW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IdxW-1:0]  last_q;
  logic [CntW-1:0]  cnt_q;

  logic [N_REQ-1:0] pick;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_vld;
  logic             busy;

  keccak_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // last_q doubles as the owner index while BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            last_q  <= pick_idx;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (rel_i[last_q]) begin
            gnt_q   <= '0;
            cnt_q   <= CntW'(FLUSH_CYC);
            state_q <= StFlush;
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q == StBusy);
  assign gnt_o  = gnt_q;
  assign r_out_o = k.out_data;
  assign k.core_reset = reset | (state_q == StFlush);

  // Non-owners see a full buffer so they never push into a core they do not own.
  always_comb begin
    k.in_data       = '0;
    k.in_ready      = 1'b0;
    k.is_last       = 1'b0;
    k.squeeze       = 1'b0;
    k.hold          = 1'b0;
    k.byte_num      = '0;
    k.mode          = '0;
    r_buffer_full_o = '1;
    r_buffer_last_o = '0;
    r_out_ready_o   = '0;
    if (busy) begin
      k.in_data                = r_in_i[32'(last_q) * 64 +: 64];
      k.in_ready               = r_in_ready_i[last_q];
      k.is_last                = r_is_last_i[last_q];
      k.squeeze                = r_squeeze_i[last_q];
      k.hold                   = r_hold_i[last_q];
      k.byte_num               = r_byte_num_i[32'(last_q) * 3 +: 3];
      k.mode                   = r_mode_i[32'(last_q) * 2 +: 2];
      r_buffer_full_o[last_q]  = k.buffer_full;
      r_buffer_last_o[last_q]  = k.buffer_last;
      r_out_ready_o[last_q]    = k.out_ready;
    end
  end

endmodule
